// File: rtl/noc_pkg.sv
// Shared definitions for the NoC injector: flit type codes, FSM states
// and the width helpers every file derives its port widths from.
package noc_pkg;

  typedef enum logic [1:0] {
    TAIL_FLIT = 2'b00,
    HEAD_FLIT = 2'b01,
    BODY_FLIT = 2'b10,
    HEADER    = 2'b11
  } flit_type_e;

  // A packet with payload carries one head and one tail around its bodies.
  localparam int unsigned HEAD_TAIL = 2;

  typedef enum logic [1:0] {
    IDLE,
    SEND_HEAD,
    SEND_DATA
  } state_e;

  // Clamped to 1 so a single-node or single-VC build keeps a legal width.
  function automatic int unsigned dest_node_width(input int unsigned nodes);
    return (nodes > 1) ? $clog2(nodes) : 1;
  endfunction

  function automatic int unsigned vc_width(input int unsigned vcs);
    return (vcs > 1) ? $clog2(vcs) : 1;
  endfunction

  function automatic int unsigned flit_total_width(input int unsigned vcs,
                                                   input int unsigned data_w);
    return 2 + vc_width(vcs) + data_w;
  endfunction

endpackage

// File: rtl/noc_packet_injector_if.sv
// Request and flit/credit bundle between a packet source and the injector.
// master = request side, slave = injector side.
interface noc_packet_injector_if import noc_pkg::*; #(
  parameter int unsigned NUM_OF_NODES            = 8,
  parameter int unsigned FLIT_DATA_WIDTH         = 16,
  parameter int unsigned NUM_OF_VIRTUAL_CHANNELS = 2,
  parameter int unsigned MAX_PKT_LEN             = 7
);

  localparam int unsigned DEST_NODE_WIDTH  = dest_node_width(NUM_OF_NODES);
  localparam int unsigned VC_W             = vc_width(NUM_OF_VIRTUAL_CHANNELS);
  localparam int unsigned LEN_W            = $clog2(MAX_PKT_LEN + 1);
  localparam int unsigned FLIT_TOTAL_WIDTH =
    flit_total_width(NUM_OF_VIRTUAL_CHANNELS, FLIT_DATA_WIDTH);

  logic                               req_valid;
  logic                               req_ready;
  logic [DEST_NODE_WIDTH-1:0]         req_dest;
  logic [VC_W-1:0]                    req_vc;
  logic [LEN_W-1:0]                   req_len;
  logic [FLIT_DATA_WIDTH-1:0]         req_payload;
  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] credit_in;
  logic [FLIT_TOTAL_WIDTH-1:0]        flit_out;
  logic                               flit_valid;
  logic                               pkt_sent;
  logic                               credit_error;

  modport master (
    output req_valid, req_dest, req_vc, req_len, req_payload, credit_in,
    input  req_ready, flit_out, flit_valid, pkt_sent, credit_error
  );

  modport slave (
    input  req_valid, req_dest, req_vc, req_len, req_payload, credit_in,
    output req_ready, flit_out, flit_valid, pkt_sent, credit_error
  );

endinterface

// File: rtl/noc_credit_counter.sv
// Credit counter for one downstream VC buffer, counting free slots from
// VC_DEPTH down to 0; a return at full depth saturates and flags overflow.
module noc_credit_counter #(
  parameter int unsigned VC_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic launch,
  input  logic credit_return,
  output logic has_credit,
  output logic overflow
);

  localparam int unsigned CW = $clog2(VC_DEPTH + 1);

  logic [CW-1:0] count_q, count_d;

  // A launch and a return in the same cycle cancel out.
  always_comb begin
    count_d  = count_q;
    overflow = 1'b0;
    if (launch && !credit_return) begin
      count_d = count_q - CW'(1);
    end else if (credit_return && !launch) begin
      if (count_q == CW'(VC_DEPTH)) begin
        overflow = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  assign has_credit = (count_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= CW'(VC_DEPTH);
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/noc_packet_injector.sv
// Network-interface source stage: serializes packet requests into
// head/body/tail (or single HEADER) flits under per-VC credit flow control.
module noc_packet_injector import noc_pkg::*; #(
  parameter int unsigned NUM_OF_NODES            = 8,
  parameter int unsigned FLIT_DATA_WIDTH         = 16,
  parameter int unsigned NODE_BUFFER_WIDTH       = 32,
  parameter int unsigned NUM_OF_VIRTUAL_CHANNELS = 2,
  parameter int unsigned NODE_ID                 = 0,
  parameter int unsigned MAX_PKT_LEN             = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  noc_packet_injector_if.slave  bus
);

  localparam int unsigned DEST_W  = dest_node_width(NUM_OF_NODES);
  localparam int unsigned VC_W    = vc_width(NUM_OF_VIRTUAL_CHANNELS);
  localparam int unsigned LEN_W   = $clog2(MAX_PKT_LEN + 1);
  localparam int unsigned FLIT_W  = flit_total_width(NUM_OF_VIRTUAL_CHANNELS,
                                                     FLIT_DATA_WIDTH);
  localparam int unsigned VC_DEPTH = NODE_BUFFER_WIDTH / FLIT_DATA_WIDTH;
  localparam int unsigned PAD_W   = FLIT_DATA_WIDTH - 2 * DEST_W;
  localparam int unsigned NVC     = NUM_OF_VIRTUAL_CHANNELS;

  state_e                     state_q, state_d;
  logic [DEST_W-1:0]          dest_q, dest_d;
  logic [VC_W-1:0]            vc_q, vc_d;
  logic [LEN_W-1:0]           rem_q, rem_d;
  logic [FLIT_DATA_WIDTH-1:0] word_q, word_d;
  logic [FLIT_W-1:0]          flit_q, flit_d;
  logic                       flit_valid_q, flit_valid_d;
  logic                       pkt_sent_q, pkt_sent_d;
  logic                       credit_error_q;

  logic [NVC-1:0]             has_credit;
  logic [NVC-1:0]             launch_vec;
  logic [NVC-1:0]             overflow;
  logic [LEN_W-1:0]           req_len_c;
  logic                       can_send;
  logic [FLIT_DATA_WIDTH-1:0] head_data;
  flit_type_e                 ftype;
  logic [FLIT_DATA_WIDTH-1:0] fdata;

  // Oversized lengths only exist when MAX_PKT_LEN leaves spare codes.
  if (MAX_PKT_LEN == (1 << LEN_W) - 1) begin : g_no_clamp
    assign req_len_c = bus.req_len;
  end else begin : g_clamp
    assign req_len_c = (bus.req_len > LEN_W'(MAX_PKT_LEN)) ?
                       LEN_W'(MAX_PKT_LEN) : bus.req_len;
  end

  for (genvar v = 0; v < NVC; v++) begin : g_credit
    noc_credit_counter #(
      .VC_DEPTH (VC_DEPTH)
    ) u_credit (
      .clk           (clk),
      .reset         (reset),
      .launch        (launch_vec[v]),
      .credit_return (bus.credit_in[v]),
      .has_credit    (has_credit[v]),
      .overflow      (overflow[v])
    );
  end

  assign can_send  = has_credit[vc_q];
  assign head_data = {dest_q, DEST_W'(NODE_ID), {PAD_W{1'b0}}};

  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    vc_d         = vc_q;
    rem_d        = rem_q;
    word_d       = word_q;
    flit_valid_d = 1'b0;
    pkt_sent_d   = 1'b0;
    launch_vec   = '0;
    ftype        = TAIL_FLIT;
    fdata        = '0;
    flit_d       = '0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          dest_d  = bus.req_dest;
          vc_d    = bus.req_vc;
          rem_d   = req_len_c;
          word_d  = bus.req_payload;
          state_d = SEND_HEAD;
        end
      end

      SEND_HEAD: begin
        if (can_send) begin
          launch_vec[vc_q] = 1'b1;
          flit_valid_d     = 1'b1;
          fdata            = head_data;
          if (rem_q == '0) begin
            ftype      = HEADER;
            pkt_sent_d = 1'b1;
            state_d    = IDLE;
          end else begin
            ftype   = HEAD_FLIT;
            state_d = SEND_DATA;
          end
        end
      end

      SEND_DATA: begin
        if (can_send) begin
          launch_vec[vc_q] = 1'b1;
          flit_valid_d     = 1'b1;
          fdata            = word_q;
          if (rem_q == LEN_W'(1)) begin
            ftype      = TAIL_FLIT;
            pkt_sent_d = 1'b1;
            state_d    = IDLE;
          end else begin
            ftype  = BODY_FLIT;
            rem_d  = rem_q - LEN_W'(1);
            word_d = word_q + FLIT_DATA_WIDTH'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (flit_valid_d) begin
      flit_d = {ftype, vc_q, fdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      dest_q         <= '0;
      vc_q           <= '0;
      rem_q          <= '0;
      word_q         <= '0;
      flit_q         <= '0;
      flit_valid_q   <= 1'b0;
      pkt_sent_q     <= 1'b0;
      credit_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      dest_q         <= dest_d;
      vc_q           <= vc_d;
      rem_q          <= rem_d;
      word_q         <= word_d;
      flit_q         <= flit_d;
      flit_valid_q   <= flit_valid_d;
      pkt_sent_q     <= pkt_sent_d;
      credit_error_q <= credit_error_q | (|overflow);
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.flit_out     = flit_q;
  assign bus.flit_valid   = flit_valid_q;
  assign bus.pkt_sent     = pkt_sent_q;
  assign bus.credit_error = credit_error_q;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Self-checking bench for noc_packet_injector: a flit-list/credit model checked
// every cycle, plus literal expectations on the directed scenarios.
module tb_noc_packet_injector;

  localparam int unsigned NODE_ID  = 0;
  localparam int unsigned VC_DEPTH = 2;

  logic clk;
  logic reset;

  noc_packet_injector_if #(
    .NUM_OF_NODES            (8),
    .FLIT_DATA_WIDTH         (16),
    .NUM_OF_VIRTUAL_CHANNELS (2),
    .MAX_PKT_LEN             (7)
  ) bus ();

  noc_packet_injector #(
    .NUM_OF_NODES            (8),
    .FLIT_DATA_WIDTH         (16),
    .NODE_BUFFER_WIDTH       (32),
    .NUM_OF_VIRTUAL_CHANNELS (2),
    .NODE_ID                 (NODE_ID),
    .MAX_PKT_LEN             (7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: the packet still to be launched as a list of flits, plus free slots per VC.
  logic [18:0] pend[$];
  int          pend_vc;
  int          cred[2];
  logic        m_err, m_valid, m_sent, m_ready;
  logic [18:0] m_flit;
  logic        launched, lv, rv;

  function automatic void expand(input int d, input int v, input int l,
                                 input logic [15:0] p);
    logic [15:0] hd, w;
    hd      = 16'(d * 8192 + NODE_ID * 1024);
    pend_vc = v;
    if (l == 0) begin
      pend.push_back({2'b11, 1'(v), hd});
    end else begin
      pend.push_back({2'b01, 1'(v), hd});
      w = p;
      for (int i = 0; i < l; i++) begin
        pend.push_back({(i == l - 1) ? 2'b00 : 2'b10, 1'(v), w});
        w = w + 16'd1;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      pend.delete();
      pend_vc = 0;
      cred[0] = VC_DEPTH;
      cred[1] = VC_DEPTH;
      m_err   = 1'b0;
      m_valid = 1'b0;
      m_sent  = 1'b0;
      m_flit  = '0;
    end else begin
      launched = 1'b0;
      m_valid  = 1'b0;
      m_sent   = 1'b0;
      m_flit   = '0;
      if (pend.size() > 0 && cred[pend_vc] > 0) begin
        m_flit   = pend.pop_front();
        m_valid  = 1'b1;
        m_sent   = (pend.size() == 0);
        launched = 1'b1;
      end
      for (int v = 0; v < 2; v++) begin
        lv = launched && (v == pend_vc);
        rv = bus.credit_in[v];
        if (lv && !rv) cred[v]--;
        else if (rv && !lv) begin
          if (cred[v] == VC_DEPTH) m_err = 1'b1;
          else cred[v]++;
        end
      end
      if (pend.size() == 0 && !launched && bus.req_valid)
        expand(int'(bus.req_dest), int'(bus.req_vc), int'(bus.req_len),
               bus.req_payload);
    end
    m_ready = (pend.size() == 0);
  end

  logic [18:0] flit_log[$];
  logic        sent_log[$];

  always @(negedge clk) begin
    check("flit_valid", bus.flit_valid, m_valid);
    check("pkt_sent", bus.pkt_sent, m_sent);
    check("req_ready", bus.req_ready, m_ready);
    check("credit_error", bus.credit_error, m_err);
    if (m_valid) check("flit_out", bus.flit_out, m_flit);
    if (bus.flit_valid) begin
      flit_log.push_back(bus.flit_out);
      sent_log.push_back(bus.pkt_sent);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready();
    int c = 0;
    while (!bus.req_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("ready_timeout", bus.req_ready, 1'b1);
  endtask

  task automatic wait_log(input int n);
    int c = 0;
    while (flit_log.size() < n && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("flit_timeout", 32'(flit_log.size() >= n), 32'd1);
  endtask

  task automatic send_req(input int d, input int v, input int l,
                          input logic [15:0] p);
    wait_ready();
    bus.req_valid   = 1'b1;
    bus.req_dest    = 3'(d);
    bus.req_vc      = 1'(v);
    bus.req_len     = 3'(l);
    bus.req_payload = p;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic pulse(input logic [1:0] mask);
    bus.credit_in = mask;
    @(negedge clk);
    bus.credit_in = 2'b00;
  endtask

  function automatic logic [18:0] logged(input int i);
    return (i < flit_log.size()) ? flit_log[i] : 19'h7FFFF;
  endfunction

  function automatic logic logged_sent(input int i);
    return (i < sent_log.size()) ? sent_log[i] : 1'bx;
  endfunction

  int base;

  initial begin
    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_dest    = '0;
    bus.req_vc      = '0;
    bus.req_len     = '0;
    bus.req_payload = '0;
    bus.credit_in   = '0;
    idle(3);
    check("rst_flit_valid", bus.flit_valid, 1'b0);
    check("rst_flit_out", bus.flit_out, 19'h0);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_credit_error", bus.credit_error, 1'b0);
    reset = 1'b0;
    idle(1);

    // Single HEADER to node 1 on vc 0.
    base = flit_log.size();
    send_req(1, 0, 0, 16'h0000);
    wait_log(base + 1);
    check("hdr_flit", logged(base), {2'b11, 1'b0, 16'h2000});
    check("hdr_sent", logged_sent(base), 1'b1);
    wait_ready();
    idle(1);
    pulse(2'b01);
    idle(1);

    // 3-flit packet with wrapping payload; stalls with credit 0 before the tail.
    base = flit_log.size();
    send_req(3, 0, 2, 16'hFFFF);
    wait_log(base + 2);
    check("p3_head", logged(base), {2'b01, 1'b0, 16'h6000});
    check("p3_body", logged(base + 1), {2'b10, 1'b0, 16'hFFFF});
    check("p3_body_sent", logged_sent(base + 1), 1'b0);
    idle(5);
    check("p3_stall_count", flit_log.size(), base + 2);
    check("p3_stall_ready", bus.req_ready, 1'b0);
    pulse(2'b01);
    wait_log(base + 3);
    check("p3_tail", logged(base + 2), {2'b00, 1'b0, 16'h0000});
    check("p3_tail_sent", logged_sent(base + 2), 1'b1);
    wait_ready();
    idle(1);

    // VC isolation: vc 0 is empty, vc 1 flows freely.
    base = flit_log.size();
    send_req(5, 1, 1, 16'h00AB);
    wait_log(base + 2);
    check("vc1_head", logged(base), {2'b01, 1'b1, 16'hA000});
    check("vc1_tail", logged(base + 1), {2'b00, 1'b1, 16'h00AB});
    wait_ready();
    idle(1);
    pulse(2'b11);
    pulse(2'b11);
    check("restore_no_err", bus.credit_error, 1'b0);

    // Launch and return together on vc 0 at credit 1, then overflow.
    send_req(0, 0, 0, 16'h0000);
    wait_ready();
    idle(1);
    bus.req_valid   = 1'b1;
    bus.req_dest    = 3'd6;
    bus.req_vc      = 1'b0;
    bus.req_len     = 3'd0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    pulse(2'b01);
    wait_ready();
    idle(1);
    pulse(2'b01);
    idle(1);
    check("same_cycle_no_err", bus.credit_error, 1'b0);
    pulse(2'b01);
    check("overflow_err", bus.credit_error, 1'b1);
    idle(2);

    // Reset while stalled mid-packet, then a clean packet.
    base = flit_log.size();
    send_req(2, 0, 5, 16'h0100);
    wait_log(base + 2);
    check("mid_body", logged(base + 1), {2'b10, 1'b0, 16'h0100});
    idle(2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("post_rst_valid", bus.flit_valid, 1'b0);
    check("post_rst_ready", bus.req_ready, 1'b1);
    check("post_rst_err", bus.credit_error, 1'b0);
    idle(1);
    base = flit_log.size();
    send_req(4, 0, 1, 16'h1234);
    wait_log(base + 2);
    check("new_head", logged(base), {2'b01, 1'b0, 16'h8000});
    check("new_tail", logged(base + 1), {2'b00, 1'b0, 16'h1234});
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
